// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter: fixed-priority sharing of the PDP-8 memory port between IFU read, EX read and EX write.
// Define PDP8_ARB_FAIRNESS_EN to force an IFU grant after STARVE_LIMIT consecutive EX grants.
module pdp8_mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 12,
    parameter int RD_TIMEOUT   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_rd_req,
    input  logic [ADDR_W-1:0] ifu_rd_addr,
    output logic [DATA_W-1:0] ifu_rd_data,
    output logic              ifu_rd_done,
    input  logic              ex_rd_req,
    input  logic [ADDR_W-1:0] ex_rd_addr,
    output logic [DATA_W-1:0] ex_rd_data,
    output logic              ex_rd_done,
    input  logic              ex_wr_req,
    input  logic [ADDR_W-1:0] ex_wr_addr,
    input  logic [DATA_W-1:0] ex_wr_data,
    output logic              ex_wr_done,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              rd_err
);
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, DONE} state_t;

    state_t            state, state_n;
    logic              ifu_pend, exr_pend, exw_pend;
    logic [ADDR_W-1:0] ifu_addr_h, exr_addr_h, exw_addr_h;
    logic [DATA_W-1:0] exw_data_h;
    logic [TW-1:0]     tcnt;
    logic              owner_ex, err_q;
    logic              force_ifu, gnt_w, gnt_r, gnt_i, rd_hit, rd_to;

`ifdef PDP8_ARB_FAIRNESS_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;
    always_ff @(posedge clk) begin
        if (reset || gnt_i || !ifu_pend)
            starve_cnt <= '0;
        else if (gnt_w || gnt_r)
            starve_cnt <= starve_cnt + 1'b1;
    end
    assign force_ifu = ifu_pend && (starve_cnt == SW'(STARVE_LIMIT));
`else
    assign force_ifu = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        gnt_w   = (state == IDLE) && exw_pend && !force_ifu;
        gnt_r   = (state == IDLE) && exr_pend && !exw_pend && !force_ifu;
        gnt_i   = (state == IDLE) && ifu_pend && (force_ifu || !(exw_pend || exr_pend));
        rd_hit  = (state == RD_WAIT) && mem_rd_valid;
        rd_to   = (state == RD_WAIT) && !mem_rd_valid && (tcnt == TW'(RD_TIMEOUT - 1));
        state_n = gnt_w                              ? WR      :
                  (gnt_r || gnt_i)                   ? RD_WAIT :
                  (rd_hit || rd_to)                  ? DONE    :
                  (state == WR || state == DONE)     ? IDLE    : state;
        mem_wr_en   = (state == WR);
        ex_wr_done  = (state == WR);
        mem_rd_en   = (state == RD_WAIT) && (tcnt == '0);
        ifu_rd_done = (state == DONE) && !owner_ex;
        ex_rd_done  = (state == DONE) && owner_ex;
        rd_err      = (state == DONE) && err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ifu_pend    <= 1'b0;
            exr_pend    <= 1'b0;
            exw_pend    <= 1'b0;
            ifu_addr_h  <= '0;
            exr_addr_h  <= '0;
            exw_addr_h  <= '0;
            exw_data_h  <= '0;
            tcnt        <= '0;
            owner_ex    <= 1'b0;
            err_q       <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            ifu_rd_data <= '0;
            ex_rd_data  <= '0;
        end else begin
            state    <= state_n;
            // a grant implies pending, so a same-cycle request is always dropped
            ifu_pend <= !gnt_i && (ifu_pend || ifu_rd_req);
            exr_pend <= !gnt_r && (exr_pend || ex_rd_req);
            exw_pend <= !gnt_w && (exw_pend || ex_wr_req);
            if (ifu_rd_req && !ifu_pend)
                ifu_addr_h <= ifu_rd_addr;
            if (ex_rd_req && !exr_pend)
                exr_addr_h <= ex_rd_addr;
            if (ex_wr_req && !exw_pend) begin
                exw_addr_h <= ex_wr_addr;
                exw_data_h <= ex_wr_data;
            end
            if (gnt_w) begin
                mem_addr    <= exw_addr_h;
                mem_wr_data <= exw_data_h;
            end
            if (gnt_r || gnt_i) begin
                mem_addr <= gnt_r ? exr_addr_h : ifu_addr_h;
                owner_ex <= gnt_r;
                tcnt     <= '0;
            end else if (state == RD_WAIT && !mem_rd_valid)
                tcnt <= tcnt + 1'b1;
            if (rd_hit || rd_to) begin
                err_q <= rd_to;
                if (owner_ex)
                    ex_rd_data <= rd_to ? '0 : mem_rd_data;
                else
                    ifu_rd_data <= rd_to ? '0 : mem_rd_data;
            end
        end
    end
endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// tb_pdp8_mem_arbiter: directed scoreboard bench for pdp8_mem_arbiter with a behavioural memory.
module tb_pdp8_mem_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        ifu_rd_req = 0, ex_rd_req = 0, ex_wr_req = 0;
    logic [11:0] ifu_rd_addr = 0, ex_rd_addr = 0, ex_wr_addr = 0, ex_wr_data = 0;
    logic [11:0] ifu_rd_data, ex_rd_data, mem_addr, mem_wr_data;
    logic [11:0] mem_rd_data = 0;
    logic        mem_rd_valid = 0;
    logic        ifu_rd_done, ex_rd_done, ex_wr_done, mem_rd_en, mem_wr_en, rd_err;

    always #5 clk = ~clk;

    pdp8_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data), .ifu_rd_done(ifu_rd_done),
        .ex_rd_req(ex_rd_req), .ex_rd_addr(ex_rd_addr), .ex_rd_data(ex_rd_data), .ex_rd_done(ex_rd_done),
        .ex_wr_req(ex_wr_req), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_wr_done(ex_wr_done),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .rd_err(rd_err)
    );

    typedef struct packed {logic wr; logic [11:0] addr; logic [11:0] data;} mop_t;
    typedef struct packed {logic [1:0] who; logic [11:0] data; logic err;} dop_t;

    mop_t        mq[$];
    dop_t        dq[$];
    logic [11:0] mem [0:4095];
    int          mem_lat = 2;
    int          checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_m(input logic wr, input logic [11:0] a, input logic [11:0] d);
        mq.push_back('{wr: wr, addr: a, data: d});
    endtask

    task automatic push_d(input logic [1:0] who, input logic [11:0] d, input logic err);
        dq.push_back('{who: who, data: d, err: err});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && (mq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
        chk(tag, mq.size() + dq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // memory model: returns mem[addr] mem_lat cycles after the read strobe, never if mem_lat < 0
    initial begin
        logic [11:0] a;
        int          l;
        for (int i = 0; i < 4096; i++) mem[i] = 12'(i) ^ 12'o5252;
        forever begin
            @(negedge clk);
            if (mem_wr_en === 1'b1) mem[mem_addr] = mem_wr_data;
            if (mem_rd_en === 1'b1 && mem_lat >= 0) begin
                a = mem_addr;
                l = mem_lat;
                repeat (l) @(negedge clk);
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem[a];
                @(negedge clk);
                mem_rd_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        mop_t m;
        dop_t d;
        int   n;
        if (reset === 1'b0) begin
            if (mem_rd_en === 1'b1 || mem_wr_en === 1'b1) begin
                chk("mem_excl", 32'(mem_rd_en & mem_wr_en), 0);
                if (mq.size() == 0) chk("mem_unexpected", 1, 0);
                else begin
                    m = mq.pop_front();
                    chk("mem_kind", 32'(mem_wr_en), 32'(m.wr));
                    chk("mem_addr", 32'(mem_addr), 32'(m.addr));
                    if (m.wr) chk("mem_wdata", 32'(mem_wr_data), 32'(m.data));
                end
            end
            n = int'(ifu_rd_done) + int'(ex_rd_done) + int'(ex_wr_done);
            if (n != 0) begin
                chk("done_onehot", n, 1);
                if (dq.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    d = dq.pop_front();
                    chk("done_who", ex_wr_done ? 2 : ex_rd_done ? 1 : 0, 32'(d.who));
                    if (!ex_wr_done) chk("rd_data", 32'(ex_rd_done ? ex_rd_data : ifu_rd_data), 32'(d.data));
                    chk("rd_err", 32'(rd_err), 32'(d.err));
                end
            end else if (rd_err === 1'b1) chk("rd_err_stray", 1, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({mem_rd_en, mem_wr_en, ex_wr_done, ex_rd_done, ifu_rd_done, rd_err}), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wr_data), 0);
        chk("rst_rd_data", 32'({ifu_rd_data, ex_rd_data}), 0);
        reset = 1'b0;
        @(negedge clk);

        // IFU read alone with exact latency
        mem[12'o0200] = 12'o7000;
        mem_lat = 2;
        push_m(0, 12'o0200, 0);
        push_d(0, 12'o7000, 0);
        ifu_rd_req = 1; ifu_rd_addr = 12'o0200;
        @(negedge clk); ifu_rd_req = 0;
        chk("t1_c1_rd_en", 32'(mem_rd_en), 0);
        @(negedge clk);
        chk("t1_c2_rd_en", 32'(mem_rd_en), 1);
        chk("t1_c2_addr", 32'(mem_addr), 32'(12'o0200));
        @(negedge clk);
        chk("t1_c3_rd_en", 32'(mem_rd_en), 0);
        @(negedge clk);
        chk("t1_c4_done", 32'(ifu_rd_done), 0);
        @(negedge clk);
        chk("t1_c5_done", 32'(ifu_rd_done), 1);
        chk("t1_c5_data", 32'(ifu_rd_data), 32'(12'o7000));
        chk("t1_c5_err", 32'(rd_err), 0);
        drain("t1_drain");

        // simultaneous requests: EX_WR > EX_RD > IFU_RD
        push_m(1, 12'o0030, 12'o1234);
        push_m(0, 12'o0020, 0);
        push_m(0, 12'o0010, 0);
        push_d(2, 0, 0);
        push_d(1, mem[12'o0020], 0);
        push_d(0, mem[12'o0010], 0);
        ifu_rd_req = 1; ifu_rd_addr = 12'o0010;
        ex_rd_req = 1; ex_rd_addr = 12'o0020;
        ex_wr_req = 1; ex_wr_addr = 12'o0030; ex_wr_data = 12'o1234;
        @(negedge clk); ifu_rd_req = 0; ex_rd_req = 0; ex_wr_req = 0;
        drain("t2_drain");
        chk("t2_hold_ifu", 32'(ifu_rd_data), 32'(mem[12'o0010]));
        chk("t2_hold_ex", 32'(ex_rd_data), 32'(mem[12'o0020]));

        // read timeout followed by a normal IFU read
        mem_lat = -1;
        push_m(0, 12'o4000, 0);
        push_m(0, 12'o0040, 0);
        push_d(1, 0, 1);
        push_d(0, mem[12'o0040], 0);
        ex_rd_req = 1; ex_rd_addr = 12'o4000;
        ifu_rd_req = 1; ifu_rd_addr = 12'o0040;
        @(negedge clk); ex_rd_req = 0; ifu_rd_req = 0;
        @(negedge clk);
        @(negedge clk); mem_lat = 2;
        repeat (14) @(negedge clk);
        chk("t3_c17_done", 32'(ex_rd_done), 0);
        @(negedge clk);
        chk("t3_c18_done", 32'(ex_rd_done), 1);
        chk("t3_c18_err", 32'(rd_err), 1);
        chk("t3_c18_data", 32'(ex_rd_data), 0);
        drain("t3_drain");
        chk("t3_hold_ex", 32'(ex_rd_data), 0);

        // duplicate IFU request while pending is ignored
        push_m(1, 12'o0050, 12'o0777);
        push_m(0, 12'o0400, 0);
        push_d(2, 0, 0);
        push_d(0, mem[12'o0400], 0);
        ex_wr_req = 1; ex_wr_addr = 12'o0050; ex_wr_data = 12'o0777;
        ifu_rd_req = 1; ifu_rd_addr = 12'o0400;
        @(negedge clk); ex_wr_req = 0; ifu_rd_addr = 12'o0500;
        @(negedge clk); ifu_rd_req = 0;
        drain("t4_drain");
        repeat (20) @(negedge clk);
        chk("t4_ifu_data", 32'(ifu_rd_data), 32'(mem[12'o0400]));

        // reset in RD_WAIT; late mem_rd_valid must be ignored
        mem_lat = 5;
        push_m(0, 12'o0600, 0);
        ifu_rd_req = 1; ifu_rd_addr = 12'o0600;
        @(negedge clk); ifu_rd_req = 0;
        @(negedge clk);
        chk("t5_rd_en", 32'(mem_rd_en), 1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("t5_rst_strobes", 32'({mem_rd_en, mem_wr_en, ex_wr_done, ex_rd_done, ifu_rd_done, rd_err}), 0);
        chk("t5_rst_addr", 32'(mem_addr), 0);
        chk("t5_rst_data", 32'({ifu_rd_data, ex_rd_data}), 0);
        repeat (6) @(negedge clk);
        mem_lat = 1;
        push_m(0, 12'o0700, 0);
        push_d(0, mem[12'o0700], 0);
        ifu_rd_req = 1; ifu_rd_addr = 12'o0700;
        @(negedge clk); ifu_rd_req = 0;
        drain("t5_drain");

        // IFU pending under back-to-back EX writes
`ifdef PDP8_ARB_FAIRNESS_EN
        nb = 4;
`else
        nb = 6;
`endif
        mem_lat = 2;
        for (int i = 0; i < 6; i++) begin
            if (i == nb) begin
                push_m(0, 12'o0300, 0);
                push_d(0, mem[12'o0300], 0);
            end
            push_m(1, 12'o0100 + 12'(i), 12'o1000 + 12'(i));
            push_d(2, 0, 0);
        end
        if (nb == 6) begin
            push_m(0, 12'o0300, 0);
            push_d(0, mem[12'o0300], 0);
        end
        ex_wr_req = 1; ex_wr_addr = 12'o0100; ex_wr_data = 12'o1000;
        ifu_rd_req = 1; ifu_rd_addr = 12'o0300;
        @(negedge clk); ex_wr_req = 0; ifu_rd_req = 0;
        for (int i = 1; i < 6; i++) begin
            for (int k = 0; k < 100 && ex_wr_done !== 1'b1; k++) @(negedge clk);
            chk("t6_wr_done_wait", 32'(ex_wr_done), 1);
            ex_wr_req = 1; ex_wr_addr = 12'o0100 + 12'(i); ex_wr_data = 12'o1000 + 12'(i);
            @(negedge clk); ex_wr_req = 0;
        end
        drain("t6_drain");

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
